// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluator: scans OAM after each start pulse and hands up to
// MAX_PER_LINE sprites covering the next line to the sprite fetch logic.
module sprite_line_evaluator #(
  parameter int unsigned NUM_SPRITES  = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned SPRITE_H     = 16,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  vcount,
  output logic [7:0]  oam_addr,
  input  logic [31:0] oam_rdata,
  output logic        spr_valid,
  input  logic        spr_ready,
  output logic [9:0]  spr_x,
  output logic [7:0]  spr_tile,
  output logic [2:0]  spr_palette,
  output logic [8:0]  spr_row,
  output logic [3:0]  spr_slot,
  output logic        busy,
  output logic        done,
  output logic [3:0]  hit_count,
  output logic        overflow
);

  localparam int unsigned      IDX_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [3:0]       MAX_HITS = 4'(MAX_PER_LINE);
  localparam logic [10:0]      SPR_H    = 11'(SPRITE_H);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [9:0]       target_q, target_d;
  logic [9:0]       x_q,      x_d;
  logic [7:0]       tile_q,   tile_d;
  logic [2:0]       pal_q,    pal_d;
  logic [8:0]       row_q,    row_d;
  logic [3:0]       slot_q,   slot_d;
  logic             valid_q,  valid_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [3:0]       hits_q,   hits_d;
  logic             ovf_q,    ovf_d;

  logic [10:0] diff;
  logic        rd_hit;
  logic        last_idx;

  // Next-state and descriptor capture; start pre-empts every state (abort/restart).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    x_d      = x_q;
    tile_d   = tile_q;
    pal_d    = pal_q;
    row_d    = row_q;
    slot_d   = slot_q;
    hits_d   = hits_q;
    ovf_d    = ovf_q;

    // Unsigned 11-bit difference: a negative result sets bit 10, so no frame wrap.
    diff     = {1'b0, target_q} - {1'b0, oam_rdata[20:11]};
    rd_hit   = oam_rdata[0] & ~diff[10] & (diff < SPR_H);
    last_idx = (idx_q == LAST_IDX);

    if (start) begin
      state_d  = S_ADDR;
      idx_d    = '0;
      hits_d   = 4'd0;
      ovf_d    = 1'b0;
      target_d = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR: state_d = S_CHECK;
        S_CHECK: begin
          if (rd_hit && (hits_q < MAX_HITS)) begin
            x_d     = oam_rdata[10:1];
            tile_d  = oam_rdata[28:21];
            pal_d   = oam_rdata[31:29];
            row_d   = 9'(diff);
            slot_d  = hits_q;
            state_d = S_EMIT;
          end else if (rd_hit) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ADDR;
          end
        end
        S_EMIT: begin
          if (spr_ready) begin
            hits_d = hits_q + 4'd1;
            if (last_idx) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_ADDR;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d  = (state_d == S_ADDR) || (state_d == S_CHECK) || (state_d == S_EMIT);
    valid_d = (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      target_q <= 10'd0;
      x_q      <= 10'd0;
      tile_q   <= 8'd0;
      pal_q    <= 3'd0;
      row_q    <= 9'd0;
      slot_q   <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hits_q   <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      x_q      <= x_d;
      tile_q   <= tile_d;
      pal_q    <= pal_d;
      row_q    <= row_d;
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hits_q   <= hits_d;
      ovf_q    <= ovf_d;
    end
  end

  assign oam_addr    = 8'(idx_q);
  assign spr_valid   = valid_q;
  assign spr_x       = x_q;
  assign spr_tile    = tile_q;
  assign spr_palette = pal_q;
  assign spr_row     = row_q;
  assign spr_slot    = slot_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign hit_count   = hits_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench for sprite_line_evaluator: a line-level reference model predicts
// descriptors and completion status; a negedge monitor checks what the DUT presents.
module tb_sprite_line_evaluator;

  localparam int NSPR   = 64;
  localparam int MAXH   = 8;
  localparam int SH     = 16;
  localparam int VTOT   = 525;

  typedef struct packed {
    logic [9:0] x;
    logic [7:0] tile;
    logic [2:0] pal;
    logic [8:0] row;
    logic [3:0] slot;
  } desc_t;

  typedef struct packed {
    logic [3:0] n;
    logic       ovf;
  } sum_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  vcount;
  logic [7:0]  oam_addr;
  logic [31:0] oam_rdata;
  logic        spr_valid;
  logic        spr_ready;
  logic [9:0]  spr_x;
  logic [7:0]  spr_tile;
  logic [2:0]  spr_palette;
  logic [8:0]  spr_row;
  logic [3:0]  spr_slot;
  logic        busy;
  logic        done;
  logic [3:0]  hit_count;
  logic        overflow;

  logic [31:0] oam [NSPR];
  desc_t       exp_q [$];
  sum_t        sum_q [$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          ready_mode = 0;

  sprite_line_evaluator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vcount     (vcount),
    .oam_addr   (oam_addr),
    .oam_rdata  (oam_rdata),
    .spr_valid  (spr_valid),
    .spr_ready  (spr_ready),
    .spr_x      (spr_x),
    .spr_tile   (spr_tile),
    .spr_palette(spr_palette),
    .spr_row    (spr_row),
    .spr_slot   (spr_slot),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read OAM port: data appears the cycle after the address.
  always @(posedge clk) oam_rdata <= oam[oam_addr[5:0]];

  initial begin
    spr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       spr_ready = 1'b1;
        1:       spr_ready = ($urandom_range(0, 9) < 3);
        default: spr_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic logic [31:0] mk(input int pal, input int tile, input int y,
                                     input int x, input bit en);
    mk = {3'(pal), 8'(tile), 10'(y), 10'(x), en};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < NSPR; i++) oam[i] = 32'd0;
  endtask

  // Reference: walk OAM in order, collect sprites whose rows cover the next line.
  task automatic model(input logic [9:0] v, input bit push_sum, output int n, output bit ovf);
    int t, y;
    logic [31:0] w;
    desc_t d;
    t   = (int'(v) + 1) % VTOT;
    n   = 0;
    ovf = 1'b0;
    for (int i = 0; i < NSPR; i++) begin
      w = oam[i];
      y = int'(w[20:11]);
      if (w[0] && t >= y && (t - y) < SH) begin
        if (n == MAXH) begin
          ovf = 1'b1;
          break;
        end
        d.x    = w[10:1];
        d.tile = w[28:21];
        d.pal  = w[31:29];
        d.row  = 9'(t - y);
        d.slot = 4'(n);
        exp_q.push_back(d);
        n++;
      end
    end
    if (push_sum) sum_q.push_back({4'(n), ovf});
  endtask

  task automatic pulse_start(input logic [9:0] v);
    @(posedge clk);
    #1;
    vcount = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_scan(input logic [9:0] v, output int cyc);
    int  n;
    bit  ovf;
    model(v, 1'b1, n, ovf);
    pulse_start(v);
    wait_done(cyc);
    repeat (2) @(posedge clk);
    #1;
    check("hit_count_held", 64'(hit_count), 64'(n));
    check("overflow_held", 64'(overflow), 64'(ovf));
    check("idle_after_done", 64'({busy, spr_valid, done}), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every presented descriptor must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (spr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_desc", 64'd1, 64'd0);
        end else begin
          check("desc", 64'({spr_x, spr_tile, spr_palette, spr_row, spr_slot}), 64'(exp_q[0]));
          if (spr_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (sum_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("done_status", 64'({hit_count, overflow}), 64'(sum_q[0]));
          check("done_no_pending_desc", 64'(exp_q.size()), 64'd0);
          void'(sum_q.pop_front());
        end
      end
    end
  end

  initial begin
    int  cyc;
    int  n;
    bit  ovf;
    int  t;
    bit  seen;
    reset  = 1'b1;
    start  = 1'b0;
    vcount = 10'd0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({oam_addr, spr_valid, spr_x, spr_tile, spr_palette, spr_row,
                                spr_slot, busy, done, hit_count, overflow}), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single hit, ready tied high: done rises on the 129th edge after start is sampled.
    ready_mode = 0;
    oam[5] = mk(2, 8'h41, 100, 320, 1'b1);
    do_scan(10'd110, cyc);
    check("single_hit_latency", 64'(cyc), 64'd129);
    check("single_hit_count", 64'(hit_count), 64'd1);

    // Reset while a descriptor is stalled.
    ready_mode = 2;
    model(10'd110, 1'b1, n, ovf);
    pulse_start(10'd110);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (spr_valid) seen = 1'b1;
    end
    check("reset_test_valid_seen", 64'(seen), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 64'({oam_addr, spr_valid, spr_x, spr_tile, spr_palette,
                                      spr_row, spr_slot, busy, done, hit_count, overflow}), 64'd0);
    exp_q.delete();
    sum_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", 64'({busy, spr_valid, done}), 64'd0);

    // Boundary rows around y=200.
    clear_oam();
    oam[0] = mk(5, 8'h10, 200, 17, 1'b1);
    do_scan(10'd198, cyc);
    check("boundary_198_miss", 64'(hit_count), 64'd0);
    do_scan(10'd199, cyc);
    do_scan(10'd214, cyc);
    do_scan(10'd215, cyc);
    check("boundary_215_miss", 64'(hit_count), 64'd0);

    // Frame wrap: last line targets line 0; sprites never wrap bottom-to-top.
    clear_oam();
    oam[63] = mk(1, 8'h22, 0, 600, 1'b1);
    do_scan(10'd524, cyc);
    check("wrap_hit", 64'(hit_count), 64'd1);
    clear_oam();
    oam[9] = mk(3, 8'h33, 520, 100, 1'b1);
    do_scan(10'd3, cyc);
    check("wrap_no_hit", 64'(hit_count), 64'd0);

    // Overflow with random backpressure: ten candidates, eight emitted.
    clear_oam();
    for (int i = 0; i < 10; i++) oam[3 + 4 * i] = mk(i % 8, 8'h80 + i, 250, 30 * i, 1'b1);
    ready_mode = 1;
    do_scan(10'd255, cyc);
    check("overflow_flag", 64'(overflow), 64'd1);
    check("overflow_count", 64'(hit_count), 64'd8);
    ready_mode = 0;

    // Abort: restart at scan cycle 40 with a different line.
    clear_oam();
    oam[0] = mk(1, 8'h01, 95, 10, 1'b1);
    oam[1] = mk(2, 8'h02, 95, 20, 1'b1);
    oam[2] = mk(3, 8'h03, 300, 30, 1'b1);
    for (int i = 40; i < 50; i++) oam[i] = mk(i % 8, i, 300, 5 * i, 1'b1);
    model(10'd100, 1'b0, n, ovf);
    pulse_start(10'd100);
    repeat (30) @(posedge clk);
    #1;
    check("abort_pre_count", 64'(hit_count), 64'd2);
    repeat (8) @(posedge clk);
    model(10'd305, 1'b1, n, ovf);
    pulse_start(10'd305);
    check("abort_cleared", 64'({hit_count, overflow}), 64'd0);
    wait_done(cyc);
    repeat (2) @(posedge clk);
    #1;
    check("abort_new_count", 64'(hit_count), 64'(n));
    check("abort_new_ovf", 64'(overflow), 64'(ovf));

    // Randomised OAM contents, lines and backpressure.
    for (int r = 0; r < 6; r++) begin
      vcount = 10'($urandom_range(0, VTOT - 1));
      t = (int'(vcount) + 1) % VTOT;
      clear_oam();
      for (int i = 0; i < NSPR; i++) begin
        if ($urandom_range(0, 3) == 0)
          oam[i] = mk($urandom_range(0, 7), $urandom_range(0, 255),
                      (t + 1024 - $urandom_range(0, 24)) % 1024,
                      $urandom_range(0, 1023), 1'b1);
        else
          oam[i] = mk($urandom_range(0, 7), $urandom_range(0, 255),
                      $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
      end
      ready_mode = r % 2;
      do_scan(vcount, cyc);
    end
    ready_mode = 0;

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
